// File: rtl/nco_tone_generator.sv
// Phase-accumulator tone source: square/saw/triangle NCO scaled by a gated
// linear attack/release envelope, emitting one signed 16-bit sample per frame.
module nco_tone_generator #(
  parameter int SAMPLE_DIV   = 1024,
  parameter int PHASE_W      = 24,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gate,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [1:0]         wave_sel,
  output logic [15:0]        sample_out,
  output logic               sample_valid,
  output logic               note_active
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [7:0]         env, env_next;
  logic [PHASE_W-1:0] phase, phase_next, phase_adv;
  logic [1:0]         wave_sel_r;
  logic               gate_m, gate_s;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [8:0]         env_up_raw;
  logic [7:0]         env_up, env_dn;

  // gate comes straight from a key/button, so it is double-flopped before use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_m <= 1'b0;
      gate_s <= 1'b0;
    end else begin
      gate_m <= gate;
      gate_s <= gate_m;
    end
  end

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign phase_adv  = phase + tuning_word;
  assign env_up_raw = {1'b0, env} + 9'(ATTACK_STEP);
  assign env_up     = env_up_raw[8] ? 8'hFF : env_up_raw[7:0];
  assign env_dn     = (env <= 8'(RELEASE_STEP)) ? 8'd0 : env - 8'(RELEASE_STEP);

  always_comb begin
    state_next = state;
    env_next   = env;
    phase_next = phase;
    case (state)
      IDLE: begin
        env_next   = 8'd0;
        phase_next = '0;
        if (gate_s) begin
          state_next = ATTACK;
          env_next   = 8'(ATTACK_STEP);
          phase_next = tuning_word;
        end
      end
      ATTACK: begin
        if (!gate_s) begin
          if (env_dn == 8'd0) begin
            state_next = IDLE;
            env_next   = 8'd0;
            phase_next = '0;
          end else begin
            state_next = RELEASE;
            env_next   = env_dn;
            phase_next = phase_adv;
          end
        end else begin
          env_next   = env_up;
          phase_next = phase_adv;
          if (env_up == 8'hFF) state_next = SUSTAIN;
        end
      end
      SUSTAIN: begin
        env_next   = 8'hFF;
        phase_next = phase_adv;
        if (!gate_s) begin
          state_next = RELEASE;
          env_next   = 8'(255 - RELEASE_STEP);
        end
      end
      RELEASE: begin
        if (gate_s) begin
          // retrigger resumes the ramp from wherever the release had reached
          state_next = ATTACK;
          env_next   = env_up;
          phase_next = phase_adv;
        end else if (env_dn == 8'd0) begin
          state_next = IDLE;
          env_next   = 8'd0;
          phase_next = '0;
        end else begin
          env_next   = env_dn;
          phase_next = phase_adv;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      env        <= 8'd0;
      phase      <= '0;
      wave_sel_r <= 2'd0;
    end else if (tick) begin
      state      <= state_next;
      env        <= env_next;
      phase      <= phase_next;
      wave_sel_r <= wave_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) note_active <= 1'b0;
    else     note_active <= (state != IDLE);
  end

  // Stage 1: waveform lookup from the top 16 phase bits
  logic [15:0]        p;
  logic [14:0]        tri_t;
  logic signed [15:0] wave, wave_r;
  logic [7:0]         env_r;
  logic               v1, v2;

  assign p     = phase[PHASE_W-1 -: 16];
  assign tri_t = p[15] ? ~p[14:0] : p[14:0];

  always_comb begin
    wave = 16'sd0;
    case (wave_sel_r)
      2'd0:    wave = p[15] ? 16'sh8000 : 16'sh7FFF;
      2'd1:    wave = p ^ 16'h8000;
      2'd2:    wave = {tri_t, 1'b0} - 16'h8000;
      default: wave = 16'sd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      wave_r <= 16'sd0;
      env_r  <= 8'd0;
    end else begin
      v1 <= tick;
      v2 <= v1;
      if (v1) begin
        wave_r <= wave;
        env_r  <= env;
      end
    end
  end

  // Stage 2: envelope scaling; >>> floors toward minus infinity
  logic signed [24:0] prod;
  assign prod = wave_r * $signed({1'b0, env_r});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out   <= 16'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= v2;
      if (v2) sample_out <= 16'(prod >>> 8);
    end
  end

endmodule

// File: doc/nco_tone_generator.md
Name: nco_tone_generator

Overview:
Upstream sample source for the I2S transmitter in the NCO path. It runs a phase-accumulator NCO with selectable square, saw or triangle waveform and a gate-driven linear attack/release envelope. Once per audio frame it produces a signed 16-bit sample, held stable on sample_out, which the transmitter latches as new_sound_sample. Runs on the 24.576 MHz system clock; the default frame rate is 24 kHz, matching one 32-bit I2S frame.

Parameters:
SAMPLE_DIV, 1024, clk cycles per output sample (24.576 MHz / 1024 = 24 kHz)
PHASE_W, 24, phase accumulator and tuning word width (>=16)
ATTACK_STEP, 8, envelope increment per sample during attack
RELEASE_STEP, 4, envelope decrement per sample during release

Ports:
clk  input  1  system clock, 24.576 MHz
rst  input  1  asynchronous, active-high reset
gate  input  1  note on/off; asynchronous (button/key), synchronised internally
tuning_word  input  PHASE_W  phase increment per sample; f = tuning_word * 24000 / 2^PHASE_W
wave_sel  input  2  0 square, 1 saw, 2 triangle, 3 silence
sample_out  output  16  signed two's-complement sample, held between updates
sample_valid  output  1  one-clk pulse when sample_out updates
note_active  output  1  high whenever the envelope state is not IDLE

Behaviour:
- Reset: async on rst high, mid-operation included. div_cnt=0, phase=0, env=0, state=IDLE, pipeline valids=0, sample_out=0, sample_valid=0, note_active=0, gate synchroniser flops=0.
- Gate is synchronised through 2 flops (gate_s). Only gate_s is used.
- Tick: div_cnt counts 0..SAMPLE_DIV-1 and wraps. tick=1 when div_cnt==SAMPLE_DIV-1. This gives exactly one tick every SAMPLE_DIV clk.
- tuning_word, wave_sel and gate_s are sampled only on tick edges. Changes between ticks have no effect, so tuning changes are phase-continuous.
- On the tick edge, envelope FSM (env is 8-bit unsigned):
  - IDLE: env=0, phase held at 0. If gate_s: go to ATTACK, env<=ATTACK_STEP, phase<=tuning_word.
  - ATTACK: if !gate_s: go to RELEASE, env<=max(env-RELEASE_STEP,0); at 0, go to IDLE instead. Else env<=min(env+ATTACK_STEP,255); at 255, go to SUSTAIN.
  - SUSTAIN: env=255. If !gate_s: go to RELEASE, env<=255-RELEASE_STEP.
  - RELEASE: if gate_s: go to ATTACK, env<=min(env+ATTACK_STEP,255), continuing from the current env. Else env<=max(env-RELEASE_STEP,0); on reaching 0, go to IDLE and phase<=0.
  - In all non-IDLE states (except an exit to IDLE), phase<=phase+tuning_word, mod 2^PHASE_W.
  - wave_sel_r<=wave_sel.
- Stage 1 (edge after tick): P=phase[PHASE_W-1:PHASE_W-16], using the updated registered phase. wave (signed 16):
  - square: P[15] ? 16'h8000 : 16'h7FFF
  - saw: P ^ 16'h8000
  - triangle: t = P[15] ? ~P[14:0] : P[14:0]; wave = {t,1'b0} - 16'h8000
  - silence: 0
  - env is captured alongside wave.
- Stage 2 (next edge): prod = wave * {1'b0,env}, signed 25-bit. sample_out<=prod[23:8] (arithmetic shift, floor). sample_valid=1 for this one cycle.
- Latency: sample_out and sample_valid update on the 2nd clk edge after the tick edge. sample_valid is never asserted for 2 consecutive cycles.
- note_active is a registered decode of state!=IDLE.
- Silence with a nonzero env gives sample_out=0 while the FSM keeps running.

Test Plan:
1. Reset: run a note, assert rst mid-frame for 3 clk -> sample_out=0, sample_valid=0, note_active=0 immediately; first sample_valid arrives SAMPLE_DIV+2 clk after rst falls, with sample_out=0.
2. Frame timing: hold gate=0 for 10 frames -> sample_valid is a single-clk pulse every exactly 1024 clk, and sample_out stays 0.
3. Attack/square: wave_sel=0, tuning_word=24'h080000, gate=1 -> first non-IDLE sample is 1023 (0x7FFF*8>>8). env follows 8,16,...,248, then 255 on the 32nd attack tick. State reaches SUSTAIN, and the sign flips every 16 samples.
4. Release: drop gate in SUSTAIN -> env 251,247,...,3, then 0 on the 64th release tick. State goes to IDLE, note_active falls, sample_out=0, and the next note starts from phase 0.
5. Waveform values: env=255, tuning_word=24'h400000. Saw at P=0x4000 gives -16320. Triangle at P=0x4000/0x8000/0xC000 gives 0/32638/-2. Silence gives 0.
6. Retrigger and timing: re-raise gate in RELEASE at env=100 -> next env=108 in ATTACK. Change tuning_word between ticks -> no effect until the next tick. A gate pulse shorter than one frame is ignored unless sampled on a tick.
